// File: rtl/core_bus_pkg.sv
// Shared types and constants for the core bus responder.
package core_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } resp_state_e;

  // Bytes per bus word for a given data width.
  function automatic int unsigned word_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Index width for a RAM of the given depth; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned WORD_BYTES = word_bytes(32);
  localparam int unsigned WS_CNT_W   = $clog2(16);

endpackage

// File: rtl/core_bus_ram.sv
// Single-port synchronous scratch RAM with registered read data.
module core_bus_ram #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read-first port: rdata shows the word as it was before a same-edge write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/core_bus_responder.sv
// Responder end of the core cyc/stb/we bus backed by a word-addressed scratch RAM.
// Optional feature: define CORE_BUS_RESP_ERR_EN to add err_o, which replaces ack_o
// for out-of-range accesses.
module core_bus_responder
  import core_bus_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEMORY_SIZE = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 1,
  parameter string                 MEMORY_FILE = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ack_o
`ifdef CORE_BUS_RESP_ERR_EN
  ,
  output logic                  err_o
`endif
);

  localparam int unsigned WB       = word_bytes(DATA_WIDTH);
  localparam int unsigned WB_SHIFT = $clog2(WB);
  localparam int unsigned DEPTH    = MEMORY_SIZE / WB;
  localparam int unsigned IDX_W    = idx_width(DEPTH);
  localparam int unsigned MEM_AW   = $clog2(MEMORY_SIZE);

  resp_state_e           state, state_n;
  logic [WS_CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]      lat_idx, lat_idx_n;
  logic                  lat_we, lat_we_n;
  logic                  lat_in_range, lat_in_range_n;
  logic [DATA_WIDTH-1:0] lat_wdata, lat_wdata_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  ack_n;
`ifdef CORE_BUS_RESP_ERR_EN
  logic                  err_n;
`endif

  logic                  req_c;
  logic [ADDR_WIDTH-1:0] offset_c;
  logic                  in_range_c;
  logic [IDX_W-1:0]      idx_c;
  logic                  ram_we_c;
  logic [IDX_W-1:0]      ram_idx_c;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Address decode: BASE_ADDR is window-aligned, so the low offset bits select the word.
  always_comb begin
    req_c      = cyc_i & stb_i;
    offset_c   = addr_i - BASE_ADDR;
    in_range_c = (addr_i >= BASE_ADDR) && ((offset_c >> MEM_AW) == '0);
    idx_c      = offset_c[WB_SHIFT +: IDX_W];
  end

  // Next-state, RAM control and registered-output values.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    lat_idx_n      = lat_idx;
    lat_we_n       = lat_we;
    lat_in_range_n = lat_in_range;
    lat_wdata_n    = lat_wdata;
    data_n         = data_o;
    ack_n          = 1'b0;
`ifdef CORE_BUS_RESP_ERR_EN
    err_n          = 1'b0;
`endif
    ram_we_c       = 1'b0;
    ram_idx_c      = lat_idx;

    case (state)
      IDLE: begin
        ram_idx_c = idx_c;
        if (req_c) begin
          lat_idx_n      = idx_c;
          lat_we_n       = we_i;
          lat_in_range_n = in_range_c;
          lat_wdata_n    = data_i;
          cnt_n          = WS_CNT_W'(WAIT_STATES);
          state_n        = BUSY;
        end
      end
      BUSY: begin
        if (!req_c) begin
          state_n = IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - WS_CNT_W'(1);
        end else begin
          state_n = ACK;
          if (lat_in_range) begin
            ack_n    = 1'b1;
            ram_we_c = lat_we;
            if (!lat_we) begin
              data_n = ram_rdata;
            end
          end else begin
`ifdef CORE_BUS_RESP_ERR_EN
            err_n = 1'b1;
`else
            ack_n = 1'b1;
            if (!lat_we) begin
              data_n = '0;
            end
`endif
          end
        end
      end
      ACK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (rst) begin
      ram_we_c = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_idx      <= '0;
      lat_we       <= 1'b0;
      lat_in_range <= 1'b0;
      lat_wdata    <= '0;
      data_o       <= '0;
      ack_o        <= 1'b0;
`ifdef CORE_BUS_RESP_ERR_EN
      err_o        <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      lat_idx      <= lat_idx_n;
      lat_we       <= lat_we_n;
      lat_in_range <= lat_in_range_n;
      lat_wdata    <= lat_wdata_n;
      data_o       <= data_n;
      ack_o        <= ack_n;
`ifdef CORE_BUS_RESP_ERR_EN
      err_o        <= err_n;
`endif
    end
  end

  core_bus_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_c),
    .idx  (ram_idx_c),
    .wdata(lat_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_core_bus_responder.sv
// Scoreboard bench for core_bus_responder: two instances (1 wait state at base 0,
// 0 wait states at base 0x2000); expectations queued at issue, checked by a monitor.
module tb_core_bus_responder;

  localparam int unsigned WS_A = 1;
  localparam int unsigned WS_B = 0;
`ifdef CORE_BUS_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    int unsigned cyc;
    logic        rd;
    logic        err;
    logic [31:0] data;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc  [2];
  logic        stb  [2];
  logic        we   [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        ack  [2];
  logic        err  [2];
  logic [31:0] last [2];

  int unsigned cycle  = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q0[$];
  exp_t        q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  core_bus_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEMORY_SIZE(4096),
    .BASE_ADDR(32'h0000_0000), .WAIT_STATES(WS_A), .MEMORY_FILE("")
  ) u_dut_a (
    .clk(clk), .rst(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .addr_i(addr[0]), .data_i(wdat[0]), .data_o(rdat[0]), .ack_o(ack[0])
`ifdef CORE_BUS_RESP_ERR_EN
    , .err_o(err[0])
`endif
  );

  core_bus_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEMORY_SIZE(4096),
    .BASE_ADDR(32'h0000_2000), .WAIT_STATES(WS_B), .MEMORY_FILE("")
  ) u_dut_b (
    .clk(clk), .rst(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .addr_i(addr[1]), .data_i(wdat[1]), .data_o(rdat[1]), .ack_o(ack[1])
`ifdef CORE_BUS_RESP_ERR_EN
    , .err_o(err[1])
`endif
  );

`ifndef CORE_BUS_RESP_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif

  function automatic int unsigned ws(input int sel);
    return (sel == 0) ? WS_A : WS_B;
  endfunction

  // Monitor: every ack/err must match the head of that instance's queue.
  task automatic mon(input int sel, input logic a, input logic e, input logic [31:0] d);
    exp_t x;
    bool_empty: begin end
    if (a || e) begin
      checks++;
      if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
        errors++;
        $display("FAIL unexpected_resp dut%0d cycle %0d: ack=%0b err=%0b, required no response",
                 sel, cycle, a, e);
      end else begin
        if (sel == 0) x = q0.pop_front();
        else          x = q1.pop_front();
        if (cycle != x.cyc) begin
          errors++;
          $display("FAIL latency dut%0d id%0d: response in cycle %0d, required cycle %0d",
                   sel, x.id, cycle, x.cyc);
        end
        checks++;
        if (a != !x.err || e != x.err) begin
          errors++;
          $display("FAIL resp_kind dut%0d id%0d: ack=%0b err=%0b, required ack=%0b err=%0b",
                   sel, x.id, a, e, !x.err, x.err);
        end
        if (x.rd || x.err) begin
          checks++;
          if (d !== x.data) begin
            errors++;
            $display("FAIL data dut%0d id%0d: data_o=%h, required %h", sel, x.id, d, x.data);
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, ack[0], err[0], rdat[0]);
    mon(1, ack[1], err[1], rdat[1]);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int sel, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    cyc[sel]  = c;
    stb[sel]  = s;
    we[sel]   = w;
    addr[sel] = a;
    wdat[sel] = d;
  endtask

  task automatic idle(input int sel);
    drive(sel, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp_v);
    end
  endtask

  // Queue the expected response and present the request. delay=1 when issued
  // during the ACK cycle of the previous transfer (not sampled until the next cycle).
  task automatic issue(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic oor, input int id,
                       input int unsigned delay);
    exp_t x;
    x.cyc = cycle + delay + ws(sel) + 2;
    x.err = oor && ERR_EN;
    x.rd  = !w;
    x.id  = id;
    if (x.err)     x.data = last[sel];
    else           x.data = exp_d;
    if (x.rd && !x.err) last[sel] = exp_d;
    if (sel == 0) q0.push_back(x);
    else          q1.push_back(x);
    drive(sel, 1'b1, 1'b1, w, a, d);
  endtask

  task automatic wait_resp(input int sel);
    for (int i = 0; i < 40; i++) begin
      step();
      if (ack[sel] || err[sel]) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout dut%0d: no response within 40 cycles, required one", sel);
  endtask

  task automatic single(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic oor, input int id);
    issue(sel, w, a, d, exp_d, oor, id, 0);
    wait_resp(sel);
    idle(sel);
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle(0);
    idle(1);
    last[0] = 32'h0;
    last[1] = 32'h0;
    repeat (3) step();
    chk("reset_ack_a",  {31'h0, ack[0]}, 32'h0);
    chk("reset_data_a", rdat[0], 32'h0);
    chk("reset_ack_b",  {31'h0, ack[1]}, 32'h0);
    chk("reset_data_b", rdat[1], 32'h0);
`ifdef CORE_BUS_RESP_ERR_EN
    chk("reset_err_a",  {31'h0, err[0]}, 32'h0);
    chk("reset_err_b",  {31'h0, err[1]}, 32'h0);
`endif
    rst = 1'b0;
    step();

    // Basic write/read with one wait state; low address bits ignored.
    single(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1);
    single(0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2);
    single(0, 1'b0, 32'h13, 32'h0,        32'hDEADBEEF, 1'b0, 3);

    // Strobe dropped while BUSY: write must not happen, no ack.
    single(0, 1'b1, 32'h08, 32'h11111111, 32'h0, 1'b0, 4);
    single(0, 1'b1, 32'h00, 32'hA0A0A0A0, 32'h0, 1'b0, 5);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h08, 32'h00001234);
    step();
    idle(0);
    repeat (4) step();
    single(0, 1'b0, 32'h08, 32'h0, 32'h11111111, 1'b0, 6);

    // Out of range just past the window: write dropped (no alias to word 0), read 0.
    single(0, 1'b1, 32'h1000, 32'h00000055, 32'h0, 1'b1, 7);
    single(0, 1'b0, 32'h00,   32'h0, 32'hA0A0A0A0,   1'b0, 8);
    single(0, 1'b0, 32'h1000, 32'h0, 32'h0,          1'b1, 9);

    // Bus changes after acceptance are ignored.
    single(0, 1'b1, 32'h34, 32'h34343434, 32'h0, 1'b0, 10);
    issue(0, 1'b1, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, 11, 0);
    step();
    drive(0, 1'b1, 1'b1, 1'b1, 32'h34, 32'h0);
    wait_resp(0);
    idle(0);
    step();
    single(0, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 12);
    single(0, 1'b0, 32'h34, 32'h0, 32'h34343434, 1'b0, 13);

    // Back-to-back reads with one wait state: period 4.
    issue(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 14, 0);
    wait_resp(0);
    issue(0, 1'b0, 32'h08, 32'h0, 32'h11111111, 1'b0, 15, 1);
    wait_resp(0);
    idle(0);
    step();

    // cyc without stb and stb without cyc are not requests.
    drive(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF);
    repeat (4) step();
    drive(0, 1'b0, 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF);
    repeat (4) step();
    idle(0);
    step();
    single(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 16);

    // Zero wait states at base 0x2000: back-to-back with stb held, period 3.
    issue(1, 1'b1, 32'h2000, 32'h0BADF00D, 32'h0, 1'b0, 20, 0);
    wait_resp(1);
    issue(1, 1'b1, 32'h2004, 32'hC0FFEE00, 32'h0, 1'b0, 21, 1);
    wait_resp(1);
    issue(1, 1'b0, 32'h2000, 32'h0, 32'h0BADF00D, 1'b0, 22, 1);
    wait_resp(1);
    issue(1, 1'b0, 32'h2004, 32'h0, 32'hC0FFEE00, 1'b0, 23, 1);
    wait_resp(1);
    idle(1);
    step();

    // Window boundaries around a non-zero base.
    single(1, 1'b0, 32'h1FFC, 32'h0, 32'h0, 1'b1, 24);
    single(1, 1'b1, 32'h2FFF, 32'h600DCAFE, 32'h0, 1'b0, 25);
    single(1, 1'b0, 32'h2FFC, 32'h0, 32'h600DCAFE, 1'b0, 26);
    single(1, 1'b0, 32'h3000, 32'h0, 32'h0, 1'b1, 27);

    // Reset on the commit edge: no ack, write discarded, data_o cleared.
    single(0, 1'b1, 32'h20, 32'hAAAA5555, 32'h0, 1'b0, 30);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(0);
    last[0] = 32'h0;
    last[1] = 32'h0;
    chk("rst_mid_ack_a",  {31'h0, ack[0]}, 32'h0);
    chk("rst_mid_data_a", rdat[0], 32'h0);
    chk("rst_mid_data_b", rdat[1], 32'h0);
    repeat (3) step();
    single(0, 1'b0, 32'h20, 32'h0, 32'hAAAA5555, 1'b0, 31);

    repeat (5) step();
    chk("pending_a", q0.size(), 32'h0);
    chk("pending_b", q1.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
